// File: rtl/pdes_rnd_pkg.sv
// Shared types for the random-number arbiter: FSM encoding and default widths.
package pdes_rnd_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADV  = 2'd1,
    WAIT = 2'd2,
    DLV  = 2'd3
  } state_t;

  localparam int RND_W_DFLT = 8;
  localparam int STAT_W     = 32;
endpackage

// File: rtl/rnd_arbiter_rr_pick.sv
// Round-robin priority picker: first unmasked request at or after ptr, wrapping at N_REQ.
// Purely combinational, zero latency; no flow control.
module rr_pick #(
  parameter int N_REQ = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [ID_W-1:0]  win_id,
  output logic             any
);
  localparam int IW = ID_W + 1;

  logic [N_REQ-1:0] live;
  logic [ID_W:0]    idx;

  assign live = req & ~mask;

  // ptr is always below N_REQ, so a single subtraction brings idx back into range
  always_comb begin
    win_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + IW'(i);
      if (idx >= IW'(N_REQ)) idx = idx - IW'(N_REQ);
      if (!any && live[idx[ID_W-1:0]]) begin
        any    = 1'b1;
        win_id = idx[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/rnd_arbiter.sv
// Shares one LFSR among N_REQ cores: round-robin grant, one lfsr_next pulse, tagged delivery.
// Latency LFSR_LAT+2 cycles from decision to rsp_valid; one value per LFSR_LAT+3 cycles.
// No backpressure on rsp; requests are level-held until served. RND_STATS_EN builds stat_grants.
module rnd_arbiter import pdes_rnd_pkg::*; #(
  parameter int N_REQ    = 8,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int RND_W    = RND_W_DFLT,
  parameter int LFSR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [RND_W-1:0]  rsp_data,
  output logic              busy,
  output logic              lfsr_next,
  input  logic [RND_W-1:0]  lfsr_rnd,
  output logic [STAT_W-1:0] stat_grants
);
  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_id;
  logic [1:0]       cnt;
  logic             skip;
  logic [N_REQ-1:0] mask;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             deliver;

  // The just-served core still holds req for one cycle after rsp_valid; hide it then.
  always_comb begin
    mask = '0;
    if (skip) mask[win_id] = 1'b1;
  end

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .mask   (mask),
    .win_id (pick_id),
    .any    (pick_any)
  );

  assign deliver = (state == WAIT) && (cnt == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      win_id    <= '0;
      cnt       <= '0;
      skip      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      lfsr_next <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          skip <= 1'b0;
          if (pick_any) begin
            win_id    <= pick_id;
            lfsr_next <= 1'b1;
            busy      <= 1'b1;
            state     <= ADV;
          end
        end
        ADV: begin
          lfsr_next <= 1'b0;
          cnt       <= 2'(LFSR_LAT - 1);
          state     <= WAIT;
        end
        WAIT: begin
          // Sample on the last WAIT edge so the value is presented during DLV
          if (deliver) begin
            rsp_valid <= 1'b1;
            rsp_id    <= win_id;
            rsp_data  <= lfsr_rnd;
            state     <= DLV;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        DLV: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          skip      <= 1'b1;
          ptr       <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RND_STATS_EN
  logic [STAT_W-1:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (deliver && (stat_q != {STAT_W{1'b1}})) begin
      stat_q <= stat_q + 1'b1;
    end
  end

  assign stat_grants = stat_q;
`else
  assign stat_grants = '0;
`endif
endmodule

// File: tb/tb_rnd_arbiter.sv
// Scoreboard bench for rnd_arbiter: LFSR_LAT=1 instance for arbitration/data, LFSR_LAT=4 for abort.
module tb_rnd_arbiter;
  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  req = 8'h00;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        lfsr_next;
  logic [7:0]  lfsr_rnd = 8'h00;
  logic [31:0] stat_grants;

  logic        rst4_n = 1'b0;
  logic [7:0]  req4 = 8'h00;
  logic        rsp_valid4;
  logic [2:0]  rsp_id4;
  logic [7:0]  rsp_data4;
  logic        busy4;
  logic        lfsr_next4;
  logic [7:0]  lfsr_rnd4 = 8'h00;
  logic [31:0] stat_grants4;
  logic [2:0]  nxt4_sr = 3'b000;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          adv_cnt = 0;
  int          rsp_cnt = 0;
  int          rsp_cnt4 = 0;
  logic [7:0]  base = 8'h00;
  exp_t        sb[$];
  exp_t        sb4[$];
  exp_t        e_m;
  exp_t        e_m4;

  rnd_arbiter #(.N_REQ(8), .ID_W(3), .RND_W(8), .LFSR_LAT(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .lfsr_next   (lfsr_next),
    .lfsr_rnd    (lfsr_rnd),
    .stat_grants (stat_grants)
  );

  rnd_arbiter #(.N_REQ(8), .ID_W(3), .RND_W(8), .LFSR_LAT(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst4_n),
    .req         (req4),
    .rsp_valid   (rsp_valid4),
    .rsp_id      (rsp_id4),
    .rsp_data    (rsp_data4),
    .busy        (busy4),
    .lfsr_next   (lfsr_next4),
    .lfsr_rnd    (lfsr_rnd4),
    .stat_grants (stat_grants4)
  );

  always #5 clk = ~clk;

  // LFSR stand-ins: the 1-cycle one yields base+k on the k-th advance; the 4-cycle one steps by 0x11.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lfsr_next) begin
      lfsr_rnd <= base + 8'(adv_cnt) + 8'd1;
      adv_cnt  <= adv_cnt + 1;
    end
    nxt4_sr <= {nxt4_sr[1:0], lfsr_next4};
    if (nxt4_sr[2]) lfsr_rnd4 <= lfsr_rnd4 + 8'h11;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", {29'd0, rsp_id}, 32'hFFFF_FFFF);
      end else begin
        e_m = sb.pop_front();
        check("rsp_id", {29'd0, rsp_id}, {29'd0, e_m.id});
        check("rsp_data", {24'd0, rsp_data}, {24'd0, e_m.data});
      end
    end
    if (rst4_n && rsp_valid4) begin
      rsp_cnt4++;
      if (sb4.size() == 0) begin
        check("unexpected_rsp4", {29'd0, rsp_id4}, 32'hFFFF_FFFF);
      end else begin
        e_m4 = sb4.pop_front();
        check("rsp4_id", {29'd0, rsp_id4}, {29'd0, e_m4.id});
        check("rsp4_data", {24'd0, rsp_data4}, {24'd0, e_m4.data});
      end
    end
  end

  task automatic push(input int id, input int data);
    exp_t e;
    e.id   = 3'(id);
    e.data = 8'(data);
    sb.push_back(e);
  endtask

  // First advance after this call makes the model return 'first'
  task automatic set_base(input logic [7:0] first);
    base = first - 8'd1 - 8'(adv_cnt);
  endtask

  task automatic wait_rsp(input bit which, input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? rsp_valid4 : rsp_valid) && n < lim);
    if (!(which ? rsp_valid4 : rsp_valid)) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    int a0;
    int r0;
    int last;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_id", {29'd0, rsp_id}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_lfsr_next", {31'd0, lfsr_next}, 32'd0);
    check("rst_stat", stat_grants, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    rst4_n = 1'b1;

    // Single request on core 2
    set_base(8'hA5);
    a0 = adv_cnt;
    push(2, 8'hA5);
    @(negedge clk);
    req = 8'b0000_0100;
    t0  = cyc;
    wait_rsp(1'b0, 20);
    check("lat1", 32'(cyc - t0), 32'd3);
    req = 8'h00;
    @(negedge clk);
    check("busy_after", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("adv_single", 32'(adv_cnt - a0), 32'd1);

    // All cores requesting from a fresh pointer
    pulse_reset();
    set_base(8'h01);
    a0 = adv_cnt;
    for (int i = 0; i < 9; i++) push(i % 8, i + 1);
    req = 8'hFF;
    last = 0;
    for (int i = 0; i < 9; i++) begin
      wait_rsp(1'b0, 20);
      if (i > 0) check("spacing", 32'(cyc - last), 32'd4);
      last = cyc;
    end
    req = 8'h00;
    repeat (4) @(negedge clk);
    check("adv_all", 32'(adv_cnt - a0), 32'd9);

    // Serve 1, then cores 1 and 6 pending with pointer at 2
    set_base(8'h01);
    push(1, 1);
    push(6, 2);
    push(1, 3);
    req = 8'b0000_0010;
    wait_rsp(1'b0, 20);
    req = 8'b0100_0010;
    wait_rsp(1'b0, 20);
    req = 8'b0000_0010;
    wait_rsp(1'b0, 20);
    req = 8'h00;
    repeat (3) @(negedge clk);

    // Core 3 withdraws right after its grant
    set_base(8'h3C);
    a0 = adv_cnt;
    r0 = rsp_cnt;
    push(3, 8'h3C);
    req = 8'b0000_1000;
    @(negedge clk);
    req = 8'h00;
    wait_rsp(1'b0, 20);
    repeat (10) @(negedge clk);
    check("withdraw_rsp_cnt", 32'(rsp_cnt - r0), 32'd1);
    check("withdraw_adv", 32'(adv_cnt - a0), 32'd1);

    // Reset in WAIT on the 4-cycle instance
    req4 = 8'h01;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", {31'd0, busy4}, 32'd1);
    rst4_n = 1'b0;
    #1;
    check("abort_rsp_valid", {31'd0, rsp_valid4}, 32'd0);
    check("abort_lfsr_next", {31'd0, lfsr_next4}, 32'd0);
    check("abort_busy", {31'd0, busy4}, 32'd0);
    check("abort_rsp_id", {29'd0, rsp_id4}, 32'd0);
    check("abort_rsp_data", {24'd0, rsp_data4}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_rsp", 32'(rsp_cnt4), 32'd0);
    begin
      exp_t e;
      e.id   = 3'd0;
      e.data = 8'h22;
      sb4.push_back(e);
    end
    rst4_n = 1'b1;
    t0 = cyc;
    wait_rsp(1'b1, 20);
    check("lat4", 32'(cyc - t0), 32'd6);
    req4 = 8'h00;
    repeat (3) @(negedge clk);
    check("rsp4_cnt", 32'(rsp_cnt4), 32'd1);

    // Grant counter after ten deliveries
    pulse_reset();
    set_base(8'h40);
    for (int i = 0; i < 10; i++) push(i % 8, 8'h40 + i);
    req = 8'hFF;
    for (int i = 0; i < 10; i++) wait_rsp(1'b0, 20);
    req = 8'h00;
`ifdef RND_STATS_EN
    check("stat_grants", stat_grants, 32'd10);
`else
    check("stat_grants", stat_grants, 32'd0);
`endif
    repeat (4) @(negedge clk);
    check("sb_left", 32'(sb.size()), 32'd0);
    check("sb4_left", 32'(sb4.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
